// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: grant state encoding,
// default sizing constants and the address range helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_EXT = 2'd2
  } arb_state_t;

  localparam int unsigned DEF_MEM_BYTES    = 2048;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  // A word access is legal only if all four bytes fit below max_addr+4.
  function automatic logic addr_out_of_range(input logic [31:0] addr,
                                             input logic [31:0] max_addr);
    return addr > max_addr;
  endfunction

endpackage

// File: rtl/arb_port_mux.sv
// 2:1 mux of the access fields (addr/wdata/we) with a registered select.
// The select is loaded with the next grant so it lines up with the state
// register in the arbiter; the data path itself is combinational.
module arb_port_mux
  import mem_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_ext_d,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  input  logic        ext_we,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic        we
);

  logic sel_ext_q;

  // Select register, cleared asynchronously with the arbiter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_ext_q <= 1'b0;
    else     sel_ext_q <= sel_ext_d;
  end

  // Route the selected requester's access fields.
  always_comb begin
    addr  = cpu_addr;
    wdata = cpu_wdata;
    we    = cpu_we;
    if (sel_ext_q) begin
      addr  = ext_addr;
      wdata = ext_wdata;
      we    = ext_we;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the CPU and the loader/debug (ext) port.
// Each grant is a one-cycle access; ext wins over a busy CPU once it has
// waited STARVE_LIMIT cycles, and a requester acked this cycle is not
// considered for the next grant.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES    = DEF_MEM_BYTES,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic [31:0] ext_rdata,
  output logic        ext_ack,
  output logic        acc_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW        = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
  localparam logic [31:0]   MAX_ADDR = 32'(MEM_BYTES - 4);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] starve_q;
  logic          cpu_live, ext_live;
  logic          grant_valid;
  logic [31:0]   mux_addr, mux_wdata;
  logic          mux_we;

  arb_port_mux u_mux (
    .clk       (clk),
    .rst       (rst),
    .sel_ext_d (state_d == GNT_EXT),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_we    (ext_we),
    .addr      (mux_addr),
    .wdata     (mux_wdata),
    .we        (mux_we)
  );

  // Grant state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Ext wait counter, saturating at the starvation limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      starve_q <= '0;
    else if (ext_ack || !ext_req) starve_q <= '0;
    else if (starve_q < LIMIT)    starve_q <= starve_q + CW'(1);
  end

  // Next grant and access outputs; a grant whose request has been dropped
  // produces no ack and no memory strobe.
  always_comb begin
    state_d     = IDLE;
    cpu_ack     = 1'b0;
    ext_ack     = 1'b0;
    grant_valid = 1'b0;
    acc_err     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    cpu_rdata   = '0;
    ext_rdata   = '0;

    cpu_ack     = (state_q == GNT_CPU) && cpu_req;
    ext_ack     = (state_q == GNT_EXT) && ext_req;
    grant_valid = cpu_ack || ext_ack;

    if (grant_valid) begin
      acc_err   = addr_out_of_range(mux_addr, MAX_ADDR);
      mem_addr  = mux_addr;
      mem_wdata = mux_wdata;
      mem_read  = !mux_we;
      mem_write = mux_we && !acc_err;
    end

    if (cpu_ack && !acc_err) cpu_rdata = mem_rdata;
    if (ext_ack && !acc_err) ext_rdata = mem_rdata;

    cpu_live = cpu_req && !cpu_ack;
    ext_live = ext_req && !ext_ack;
    if (ext_live && (!cpu_live || starve_q >= LIMIT)) state_d = GNT_EXT;
    else if (cpu_live)                                state_d = GNT_CPU;
  end

  assign cpu_stall = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: word memory model, per-cycle reference model
// of the grant rules, and directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, cpu_stall, ext_ack, acc_err, mem_read, mem_write;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:511];

  mem_port_arbiter #(.MEM_BYTES(2048), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .acc_err(acc_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory behind the port: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr[10:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[10:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the memory this cycle (0 none, 1 cpu, 2 ext)
  // and how long ext has been waiting.
  int owner = 0;
  int waited = 0;

  always @(posedge clk or posedge rst) begin
    bit c_done, e_done, c_want, e_want;
    if (rst) begin
      owner  = 0;
      waited = 0;
    end else begin
      c_done = (owner == 1) && cpu_req;
      e_done = (owner == 2) && ext_req;
      c_want = cpu_req && !c_done;
      e_want = ext_req && !e_done;
      if (e_want && (!c_want || waited >= 4)) owner = 2;
      else if (c_want)                        owner = 1;
      else                                    owner = 0;
      if (e_done || !ext_req) waited = 0;
      else if (waited < 4)    waited = waited + 1;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    bit c_a, e_a, act, err, we;
    logic [31:0] a, wd, rd;
    c_a = !rst && (owner == 1) && cpu_req;
    e_a = !rst && (owner == 2) && ext_req;
    act = c_a || e_a;
    a   = c_a ? cpu_addr  : ext_addr;
    wd  = c_a ? cpu_wdata : ext_wdata;
    we  = c_a ? cpu_we    : ext_we;
    err = act && (a > 32'd2044);
    rd  = (act && !err) ? mem[a[10:2]] : 32'h0;
    chk("m_cpu_ack",   {31'b0, cpu_ack},   {31'b0, c_a});
    chk("m_ext_ack",   {31'b0, ext_ack},   {31'b0, e_a});
    chk("m_cpu_stall", {31'b0, cpu_stall}, {31'b0, (!rst && cpu_req && !c_a) || (rst && 1'b0)});
    chk("m_acc_err",   {31'b0, acc_err},   {31'b0, err});
    chk("m_mem_read",  {31'b0, mem_read},  {31'b0, act && !we});
    chk("m_mem_write", {31'b0, mem_write}, {31'b0, act && we && !err});
    chk("m_mem_addr",  mem_addr,  act ? a  : 32'h0);
    chk("m_mem_wdata", mem_wdata, act ? wd : 32'h0);
    chk("m_cpu_rdata", cpu_rdata, c_a ? rd : 32'h0);
    chk("m_ext_rdata", ext_rdata, e_a ? rd : 32'h0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    bit got;
    for (int unsigned i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[4]   = 32'hDEADBEEF;
    mem[511] = 32'hA5A5A5A5;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;

    // Reset state
    @(negedge clk);
    chk("rst_cpu_ack", {31'b0, cpu_ack}, 32'h0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'h0);
    step();
    rst = 1'b0;
    step();

    // CPU read of 0x10: one stall cycle then ack with data
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    @(negedge clk);
    chk("cpu_rd_stall", {31'b0, cpu_stall}, 32'h1);
    chk("cpu_rd_noack", {31'b0, cpu_ack}, 32'h0);
    step();
    @(negedge clk);
    chk("cpu_rd_ack", {31'b0, cpu_ack}, 32'h1);
    chk("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
    chk("cpu_rd_stall_done", {31'b0, cpu_stall}, 32'h0);
    step();
    cpu_req = 0;

    // Ext write 0x20 then CPU read back
    ext_req = 1; ext_we = 1; ext_addr = 32'h20; ext_wdata = 32'h12345678;
    step();
    @(negedge clk);
    chk("ext_wr_ack", {31'b0, ext_ack}, 32'h1);
    chk("ext_wr_strobe", {31'b0, mem_write}, 32'h1);
    step();
    ext_req = 0; ext_we = 0;
    cpu_req = 1; cpu_addr = 32'h20;
    step();
    @(negedge clk);
    chk("cpu_rb_data", cpu_rdata, 32'h12345678);
    step();
    cpu_req = 0;
    step();

    // Simultaneous requests: CPU first, ext next cycle
    cpu_req = 1; cpu_addr = 32'h10;
    ext_req = 1; ext_addr = 32'h10;
    step();
    @(negedge clk);
    chk("sim_cpu_first", {31'b0, cpu_ack}, 32'h1);
    chk("sim_ext_wait", {31'b0, ext_ack}, 32'h0);
    step();
    cpu_req = 0;
    @(negedge clk);
    chk("sim_ext_second", {31'b0, ext_ack}, 32'h1);
    chk("sim_ext_data", ext_rdata, 32'hDEADBEEF);
    step();
    ext_req = 0;
    step();

    // CPU held continuously with ext pending: ext acked within 5 cycles
    cpu_req = 1; cpu_addr = 32'h10;
    ext_req = 1; ext_addr = 32'h20;
    n = 0; got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      n++;
      if (ext_ack) got = 1;
      else step();
    end
    chk("starve_ext_acked", {31'b0, got}, 32'h1);
    chk("starve_within_5", {31'b0, n <= 5}, 32'h1);
    step();
    ext_req = 0;
    got = 0;
    for (int i = 0; i < 3 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack) got = 1;
      else step();
    end
    chk("starve_cpu_resumes", {31'b0, got}, 32'h1);
    step();
    cpu_req = 0;
    step();

    // Out-of-range ext write at 2045: ack with error, no write
    ext_req = 1; ext_we = 1; ext_addr = 32'd2045; ext_wdata = 32'hFFFFFFFF;
    step();
    @(negedge clk);
    chk("rng_ack", {31'b0, ext_ack}, 32'h1);
    chk("rng_err", {31'b0, acc_err}, 32'h1);
    chk("rng_nowrite", {31'b0, mem_write}, 32'h0);
    step();
    ext_req = 0; ext_we = 0;
    @(negedge clk);
    chk("rng_mem_kept", mem[511], 32'hA5A5A5A5);
    // Last legal word at 2044
    ext_req = 1; ext_addr = 32'd2044;
    step();
    @(negedge clk);
    chk("edge_err", {31'b0, acc_err}, 32'h0);
    chk("edge_data", ext_rdata, 32'hA5A5A5A5);
    step();
    ext_req = 0;
    step();

    // CPU withdraws before its grant: no ack, no access
    cpu_req = 1; cpu_addr = 32'h10;
    step();
    cpu_req = 0;
    @(negedge clk);
    chk("cancel_noack", {31'b0, cpu_ack}, 32'h0);
    chk("cancel_noread", {31'b0, mem_read}, 32'h0);
    step();

    // Reset during a CPU write grant
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFEF00D;
    step();
    @(negedge clk);
    chk("rw_write_on", {31'b0, mem_write}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rw_write_killed", {31'b0, mem_write}, 32'h0);
    chk("rw_ack_killed", {31'b0, cpu_ack}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rw_release_noack", {31'b0, cpu_ack}, 32'h0);
    chk("rw_mem_untouched", mem[12], 32'h0);
    step();
    @(negedge clk);
    chk("rw_ack_after", {31'b0, cpu_ack}, 32'h1);
    step();
    cpu_req = 0; cpu_we = 0;
    @(negedge clk);
    chk("rw_mem_written", mem[12], 32'hCAFEF00D);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
